// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter multiplexing one synchronous sprite ROM port across renderers.
// Tracks each issued read with a tag pipeline and routes the returned pixel bit back.
module sprite_rom_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int TW      = 3,
    parameter int ROM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*AW-1:0]   i_addr,
    input  logic [NREQ*TW-1:0]   i_sel,
    output logic [NREQ-1:0]      o_gnt,
    output logic                 o_rom_en,
    output logic [AW-1:0]        o_rom_addr,
    output logic [TW-1:0]        o_rom_sel,
    input  logic                 i_rom_data,
    output logic [NREQ-1:0]      o_color,
    output logic [NREQ-1:0]      o_valid
);
    localparam int             PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0]  LAST_ID = PW'(NREQ - 1);

    logic [NREQ-1:0][AW-1:0]   w_addr;
    logic [NREQ-1:0][TW-1:0]   w_sel;
    logic [NREQ-1:0]           w_eff;
    logic                      w_found;
    logic [PW-1:0]             w_win;
    logic [PW-1:0]             w_idx;
    logic                      w_ret;

    logic [PW-1:0]             r_last;
    // Stage 0 is the issue stage (mirrors o_rom_en); stage ROM_LAT lines up with i_rom_data.
    logic [ROM_LAT:0]          r_tag_vld;
    logic [ROM_LAT:0][PW-1:0]  r_tag_id;

    assign w_addr = i_addr;
    assign w_sel  = i_sel;

    // Search starts just after the last winner and wraps explicitly, so any NREQ works.
    always_comb begin
        w_eff   = i_req & ~o_gnt;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = r_last;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (w_idx == LAST_ID) ? '0 : w_idx + PW'(1);
            if (!w_found && w_eff[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_gnt      <= '0;
            o_rom_addr <= '0;
            o_rom_sel  <= '0;
            r_last     <= LAST_ID;
            r_tag_vld  <= '0;
            r_tag_id   <= '0;
        end else begin
            o_gnt <= '0;
            if (w_found) begin
                o_gnt[w_win] <= 1'b1;
                o_rom_addr   <= w_addr[w_win];
                o_rom_sel    <= w_sel[w_win];
                r_last       <= w_win;
            end
            // Flush kills reads already issued; the grant made this cycle is still tracked.
            r_tag_vld <= {r_tag_vld[ROM_LAT-1:0] & {ROM_LAT{~i_flush}}, w_found};
            r_tag_id  <= {r_tag_id[ROM_LAT-1:0], w_win};
        end
    end

    assign o_rom_en = r_tag_vld[0];
    assign w_ret    = r_tag_vld[ROM_LAT] & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_color <= '0;
            o_valid <= '0;
        end else begin
            o_valid <= '0;
            if (w_ret) begin
                o_valid[r_tag_id[ROM_LAT]] <= 1'b1;
                o_color[r_tag_id[ROM_LAT]] <= i_rom_data;
            end
        end
    end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: stimulus pushes hand-computed grants/returns,
// a negedge monitor pops and compares whenever the DUT shows a grant or a return pulse.
module tb_sprite_rom_arbiter;
    localparam int NREQ = 4, AW = 8, TW = 3, ROM_LAT = 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                i_flush = 1'b0;
    logic [NREQ-1:0]     i_req = '0;
    logic [NREQ*AW-1:0]  i_addr = '0;
    logic [NREQ*TW-1:0]  i_sel = '0;
    logic [NREQ-1:0]     o_gnt;
    logic                o_rom_en;
    logic [AW-1:0]       o_rom_addr;
    logic [TW-1:0]       o_rom_sel;
    logic                i_rom_data = 1'b0;
    logic [NREQ-1:0]     o_color;
    logic [NREQ-1:0]     o_valid;

    sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .TW(TW), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_req(i_req), .i_addr(i_addr),
        .i_sel(i_sel), .o_gnt(o_gnt), .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr),
        .o_rom_sel(o_rom_sel), .i_rom_data(i_rom_data), .o_color(o_color), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    // Bench ROM, one cycle latency: pixel bit = addr[0] ^ sel[0].
    always @(posedge clk) i_rom_data <= o_rom_addr[0] ^ o_rom_sel[0];

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [AW-1:0]   addr;
        logic [TW-1:0]   sel;
        bit              tracked;
    } gexp_t;
    typedef struct {
        logic [NREQ-1:0] vld;
        logic [NREQ-1:0] color;
    } rexp_t;

    gexp_t           gq[$];
    rexp_t           rq[$];
    int              gcyc_q[$];
    gexp_t           mg;
    rexp_t           mr;
    int              cyc = 0;
    int              nchk = 0;
    int              npass = 0;
    logic [NREQ-1:0] exp_color = '0;
    logic [AW-1:0]   addr_t[NREQ];
    logic [TW-1:0]   sel_t[NREQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Expected grant for requester k using its current table entry; tracked reads also expect a return.
    task automatic expg(input int k, input bit tracked, input logic bitv);
        gq.push_back('{NREQ'(1 << k), addr_t[k], sel_t[k], tracked});
        if (tracked) begin
            exp_color[k] = bitv;
            rq.push_back('{NREQ'(1 << k), exp_color});
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] req, input logic fl);
        i_req   = req;
        i_flush = fl;
        for (int k = 0; k < NREQ; k++) begin
            i_addr[k*AW +: AW] = addr_t[k];
            i_sel[k*TW +: TW]  = sel_t[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   32'(o_gnt), 0);
        chk({tag, "_en"},    32'(o_rom_en), 0);
        chk({tag, "_addr"},  32'(o_rom_addr), 0);
        chk({tag, "_sel"},   32'(o_rom_sel), 0);
        chk({tag, "_color"}, 32'(o_color), 0);
        chk({tag, "_valid"}, 32'(o_valid), 0);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (o_gnt != '0 || o_rom_en) begin
                if (gq.size() == 0) chk("unexpected_grant", 32'({o_gnt, o_rom_en}), 0);
                else begin
                    mg = gq.pop_front();
                    chk("gnt",      32'(o_gnt), 32'(mg.gnt));
                    chk("rom_en",   32'(o_rom_en), 1);
                    chk("rom_addr", 32'(o_rom_addr), 32'(mg.addr));
                    chk("rom_sel",  32'(o_rom_sel), 32'(mg.sel));
                    if (mg.tracked) gcyc_q.push_back(cyc);
                end
            end
            if (o_valid != '0) begin
                if (rq.size() == 0) chk("unexpected_valid", 32'(o_valid), 0);
                else begin
                    mr = rq.pop_front();
                    chk("valid", 32'(o_valid), 32'(mr.vld));
                    chk("color", 32'(o_color), 32'(mr.color));
                    if (gcyc_q.size() == 0) chk("ret_latency", 32'hffff_ffff, ROM_LAT + 1);
                    else chk("ret_latency", 32'(cyc - gcyc_q.pop_front()), ROM_LAT + 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_t = '{8'h10, 8'h21, 8'h2A, 8'h32};
        sel_t  = '{3'd1, 3'd0, 3'd5, 3'd2};
        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Round-robin with all requesting: 0,1,2,3,0,1,2,3
        for (int r = 0; r < 2; r++) begin
            expg(0, 1, 1'b1); expg(1, 1, 1'b1); expg(2, 1, 1'b1); expg(3, 1, 1'b0);
        end
        for (int i = 0; i < 8; i++) drive(4'b1111, 1'b0);
        idle(4);

        // Single requester 2 held: granted every other cycle
        for (int i = 0; i < 3; i++) expg(2, 1, 1'b1);
        for (int i = 0; i < 6; i++) drive(4'b0100, 1'b0);
        idle(4);

        // Preload colours of 3 and 1 so the wrap test visibly changes them; leaves last = 1
        addr_t[3] = 8'h33;
        expg(3, 1, 1'b1);
        drive(4'b1000, 1'b0); drive(4'b0000, 1'b0);
        addr_t[1] = 8'h20;
        expg(1, 1, 1'b0);
        drive(4'b0010, 1'b0); drive(4'b0000, 1'b0);
        idle(3);

        // req=1010 with last=1: grant 3 (bit 0) then 1 (bit 1)
        addr_t[3] = 8'h32;
        addr_t[1] = 8'h21;
        expg(3, 1, 1'b0); expg(1, 1, 1'b1);
        drive(4'b1010, 1'b0); drive(4'b0010, 1'b0); drive(4'b0000, 1'b0);
        idle(4);

        // Flush in the o_gnt=0001 cycle: read 0 discarded, grant 1 made that cycle still returns
        addr_t[0] = 8'h11;
        addr_t[1] = 8'h20;
        expg(0, 0, 1'b0); expg(1, 1, 1'b0);
        drive(4'b0011, 1'b0); drive(4'b0010, 1'b1); drive(4'b0000, 1'b0);
        idle(4);
        chk("flush_color0_held", 32'(o_color[0]), 1);

        // Async reset with reads in flight
        expg(2, 0, 1'b0); expg(3, 0, 1'b0);
        drive(4'b1111, 1'b0); drive(4'b1111, 1'b0); drive(4'b1111, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        gq.delete(); rq.delete(); gcyc_q.delete();
        exp_color = '0;
        @(posedge clk); #1;
        i_req = '0;
        rst_n = 1'b1;
        expg(0, 1, 1'b0); expg(1, 1, 1'b0);
        drive(4'b1111, 1'b0); drive(4'b1110, 1'b0); drive(4'b0000, 1'b0);
        idle(5);

        chk("grants_drained",  32'(gq.size()), 0);
        chk("returns_drained", 32'(rq.size()), 0);
        chk("tags_drained",    32'(gcyc_q.size()), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
